// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the fetch port, the load/store port, the memory and the arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              stall_if;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [2:0]        dm_read_part;
    logic [1:0]        dm_write_part;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_read_part;
    logic [1:0]        mem_write_part;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata, if_err, stall_if,
        input  dm_req, dm_we, dm_addr, dm_read_part, dm_write_part, dm_wdata,
        output dm_gnt, dm_valid, dm_rdata, dm_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output mem_read_part, mem_write_part,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata, if_err, stall_if,
        output dm_req, dm_we, dm_addr, dm_read_part, dm_write_part, dm_wdata,
        input  dm_gnt, dm_valid, dm_rdata, dm_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_read_part, mem_write_part,
        output mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: fetch vs load/store, one grant per cycle,
// registered one-cycle response, anti-starvation for fetch, illegal access filtering.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_DM = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        starve_cnt;
    logic              starved;
    logic              if_ok;
    logic              dm_ok;
    logic              if_win;
    logic              dm_win;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_err_q;
    logic              dm_err_q;

    always_comb begin
        if_ok = (bus.if_addr[1:0] == 2'b00);
        dm_ok = 1'b0;
        if (bus.dm_we) begin
            case (bus.dm_write_part)
                2'd0:    dm_ok = (bus.dm_addr[1:0] == 2'b00);
                2'd1:    dm_ok = ~bus.dm_addr[0];
                2'd2:    dm_ok = 1'b1;
                default: dm_ok = 1'b0;
            endcase
        end else begin
            case (bus.dm_read_part)
                3'd0:       dm_ok = (bus.dm_addr[1:0] == 2'b00);
                3'd1, 3'd2: dm_ok = ~bus.dm_addr[0];
                3'd3, 3'd4: dm_ok = 1'b1;
                default:    dm_ok = 1'b0;
            endcase
        end
    end

    // Reset masks grants so every combinational output drops at once.
    assign starved = (starve_cnt == LIMIT);
    assign if_win  = rst_n & bus.if_req & (~bus.dm_req | starved);
    assign dm_win  = rst_n & bus.dm_req & ~if_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (1'b1)
            if_win:  state_nxt = RSP_IF;
            dm_win:  state_nxt = RSP_DM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_err_q   <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            if (bus.if_req && !if_win) begin
                starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
            if (if_win) begin
                if_rdata_q <= if_ok ? bus.mem_rdata : '0;
                if_err_q   <= ~if_ok;
            end
            if (dm_win) begin
                dm_rdata_q <= (dm_ok && !bus.dm_we) ? bus.mem_rdata : '0;
                dm_err_q   <= ~dm_ok;
            end
        end
    end

    always_comb begin
        bus.if_gnt         = if_win;
        bus.dm_gnt         = dm_win;
        bus.stall_if       = rst_n & bus.if_req & ~if_win;
        bus.if_valid       = (state == RSP_IF);
        bus.dm_valid       = (state == RSP_DM);
        bus.if_err         = (state == RSP_IF) & if_err_q;
        bus.dm_err         = (state == RSP_DM) & dm_err_q;
        bus.if_rdata       = if_rdata_q;
        bus.dm_rdata       = dm_rdata_q;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wdata      = '0;
        bus.mem_read_part  = 3'd0;
        bus.mem_write_part = 2'd0;
        unique case (1'b1)
            if_win: begin
                bus.mem_read = if_ok;
                bus.mem_addr = bus.if_addr;
            end
            dm_win: begin
                bus.mem_read       = dm_ok & ~bus.dm_we;
                bus.mem_write      = dm_ok & bus.dm_we;
                bus.mem_addr       = bus.dm_addr;
                bus.mem_wdata      = bus.dm_wdata;
                bus.mem_read_part  = bus.dm_read_part;
                bus.mem_write_part = bus.dm_write_part;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Table-driven bench for unified_mem_arbiter with a byte-addressed memory model
// (combinational read, negedge write) plus hand-written reset and conflict sequences.
module tb_unified_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] mem [256];

    unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(logic [7:0] a, logic [2:0] p);
        logic [15:0] h;
        logic [7:0]  b;
        h = {mem[8'(a + 8'd1)], mem[a]};
        b = mem[a];
        case (p)
            3'd0: return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], h};
            3'd1: return {{16{h[15]}}, h};
            3'd2: return {16'h0, h};
            3'd3: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            default: return 32'h0;
        endcase
    endfunction

    always_comb bus.mem_rdata = mem_rd(bus.mem_addr, bus.mem_read_part);

    always @(negedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata[7:0];
            if (bus.mem_write_part != 2'd2)
                mem[8'(bus.mem_addr + 8'd1)] <= bus.mem_wdata[15:8];
            if (bus.mem_write_part == 2'd0) begin
                mem[8'(bus.mem_addr + 8'd2)] <= bus.mem_wdata[23:16];
                mem[8'(bus.mem_addr + 8'd3)] <= bus.mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic        ir;
        logic [7:0]  ia;
        logic        dr;
        logic        we;
        logic [7:0]  da;
        logic [2:0]  rp;
        logic [1:0]  wp;
        logic [31:0] wd;
        logic        e_ig;
        logic        e_dg;
        logic        e_st;
        logic        e_mr;
        logic        e_mw;
        logic        e_iv;
        logic        e_ie;
        logic [31:0] e_ird;
        logic        e_dv;
        logic        e_de;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.if_req        = v.ir;
        bus.if_addr       = v.ia;
        bus.dm_req        = v.dr;
        bus.dm_we         = v.we;
        bus.dm_addr       = v.da;
        bus.dm_read_part  = v.rp;
        bus.dm_write_part = v.wp;
        bus.dm_wdata      = v.wd;
    endtask

    task automatic idle();
        bus.if_req        = 1'b0;
        bus.if_addr       = 8'h0;
        bus.dm_req        = 1'b0;
        bus.dm_we         = 1'b0;
        bus.dm_addr       = 8'h0;
        bus.dm_read_part  = 3'd0;
        bus.dm_write_part = 2'd0;
        bus.dm_wdata      = 32'h0;
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".if_gnt"},    0, 32'(bus.if_gnt),    32'h0);
        chk({nm, ".dm_gnt"},    0, 32'(bus.dm_gnt),    32'h0);
        chk({nm, ".stall_if"},  0, 32'(bus.stall_if),  32'h0);
        chk({nm, ".if_valid"},  0, 32'(bus.if_valid),  32'h0);
        chk({nm, ".dm_valid"},  0, 32'(bus.dm_valid),  32'h0);
        chk({nm, ".mem_read"},  0, 32'(bus.mem_read),  32'h0);
        chk({nm, ".mem_write"}, 0, 32'(bus.mem_write), 32'h0);
        chk({nm, ".mem_addr"},  0, 32'(bus.mem_addr),  32'h0);
        chk({nm, ".if_rdata"},  0, bus.if_rdata,       32'h0);
        chk({nm, ".dm_rdata"},  0, bus.dm_rdata,       32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0C] = 8'h33;
        mem[8'h0D] = 8'hC2;
        mem[8'h0E] = 8'h20;
        mem[8'h0F] = 8'h00;
        mem[8'h50] = 8'h11;
        idle();
        rst_n = 1'b0;

        //            ir ia    dr we da    rp wp wd            ig dg st mr mw iv ie ird           dv de drd
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{1, 8'h0C, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 0, 32'h0020C233, 0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 1, 8'h51, 0, 2, 32'hA5,       0, 1, 0, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h51, 3, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h50, 0, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'hFFFFFFA5});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h53, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0000A511});
        vecs.push_back(vec_t'{1, 8'h02, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 1, 1, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h0C, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h0D, 4, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'hFFFFC233});
        vecs.push_back(vec_t'{0, 8'h00, 1, 1, 8'h50, 0, 3, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h000000C2});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h40, 5, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h0});
        vecs.push_back(vec_t'{1, 8'h0C, 1, 0, 8'h50, 0, 0, 32'h0,        0, 1, 1, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0000A511});
        vecs.push_back(vec_t'{0, 8'h00, 1, 1, 8'h52, 0, 1, 32'h0000BEEF, 0, 1, 0, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 0, 8'h50, 0, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0});
        vecs.push_back(vec_t'{0, 8'h00, 1, 1, 8'h52, 0, 0, 32'h12345678, 0, 1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 32'hBEEFA511});
        vecs.push_back(vec_t'{0, 8'h00, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            #3;
            chk("if_gnt",    i, 32'(bus.if_gnt),    32'(vecs[i].e_ig));
            chk("dm_gnt",    i, 32'(bus.dm_gnt),    32'(vecs[i].e_dg));
            chk("stall_if",  i, 32'(bus.stall_if),  32'(vecs[i].e_st));
            chk("mem_read",  i, 32'(bus.mem_read),  32'(vecs[i].e_mr));
            chk("mem_write", i, 32'(bus.mem_write), 32'(vecs[i].e_mw));
            chk("if_valid",  i, 32'(bus.if_valid),  32'(vecs[i].e_iv));
            chk("dm_valid",  i, 32'(bus.dm_valid),  32'(vecs[i].e_dv));
            chk("if_err",    i, 32'(bus.if_err),    32'(vecs[i].e_ie));
            chk("dm_err",    i, 32'(bus.dm_err),    32'(vecs[i].e_de));
            if (vecs[i].e_iv) chk("if_rdata", i, bus.if_rdata, vecs[i].e_ird);
            if (vecs[i].e_dv) chk("dm_rdata", i, bus.dm_rdata, vecs[i].e_drd);
        end

        @(posedge clk);
        #1;
        idle();
        #3;
        chk("hold.dm_rdata", 0, bus.dm_rdata, 32'h0);
        chk("hold.if_rdata", 0, bus.if_rdata, 32'h0);
        chk("misfetch.mem", 0, {mem[3], mem[2], mem[1], mem[0]}, 32'h0);

        // Conflict: dm wins four times, then the starved fetch wins once.
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h0C;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 8'h50;
        for (int c = 1; c <= 6; c++) begin
            #3;
            chk("conf.if_gnt",   c, 32'(bus.if_gnt),   32'(c == 5));
            chk("conf.dm_gnt",   c, 32'(bus.dm_gnt),   32'(c != 5));
            chk("conf.stall_if", c, 32'(bus.stall_if), 32'(c != 5));
            chk("conf.if_valid", c, 32'(bus.if_valid), 32'(c == 6));
            chk("conf.dm_valid", c, 32'(bus.dm_valid), 32'(c >= 2 && c <= 5));
            if (c == 6) chk("conf.if_rdata", c, bus.if_rdata, 32'h0020C233);
            if (c == 3) chk("conf.dm_rdata", c, bus.dm_rdata, 32'hBEEFA511);
            @(posedge clk);
            #1;
        end
        idle();

        // Reset in the middle of a grant cycle drops the owed response.
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h0C;
        #2;
        chk("rst.pre_gnt", 0, 32'(bus.if_gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.mid");
        @(posedge clk);
        #1;
        idle();
        chk_all_zero("rst.hold");
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            chk("rst.if_valid", c, 32'(bus.if_valid), 32'h0);
            chk("rst.dm_valid", c, 32'(bus.dm_valid), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
